// File: rtl/writeback_regfile_if.sv
// Writeback/register-file bus: MEM/WB stage inputs, read ports and forwarding outputs.
// The master drives the pipeline side; the slave is the writeback_regfile.
interface writeback_regfile_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              regWrite;
  logic              mux3sel;
  logic              r0Write;
  logic [DATA_W-1:0] instruction;
  logic [DATA_W-1:0] dOut;
  logic [DATA_W-1:0] dIn;
  logic [DATA_W-1:0] r0data;
  logic [ADDR_W-1:0] readAddrA;
  logic [ADDR_W-1:0] readAddrB;
  logic [DATA_W-1:0] readDataA;
  logic [DATA_W-1:0] readDataB;
  logic [DATA_W-1:0] r0Out;
  logic [DATA_W-1:0] wbData;
  logic [ADDR_W-1:0] wbDest;
  logic              wbValid;
  logic [15:0]       retireCount;

  modport master (
    output regWrite, mux3sel, r0Write, instruction, dOut, dIn, r0data, readAddrA, readAddrB,
    input  readDataA, readDataB, r0Out, wbData, wbDest, wbValid, retireCount
  );

  modport slave (
    input  regWrite, mux3sel, r0Write, instruction, dOut, dIn, r0data, readAddrA, readAddrB,
    output readDataA, readDataB, r0Out, wbData, wbDest, wbValid, retireCount
  );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback select, register file with dedicated r0 write path, write-through read ports
// and a retired-write counter.
module writeback_regfile #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DEST_LSB = 8
) (
  input logic                clk,
  input logic                rst,
  writeback_regfile_if.slave bus
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [15:0]       retire_q;

  logic              reg_write;
  logic              r0_write;
  logic [DATA_W-1:0] r0_data;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_dest;

  assign reg_write = bus.regWrite;
  assign r0_write  = bus.r0Write;
  assign r0_data   = bus.r0data;
  assign wb_data   = bus.mux3sel ? bus.dOut : bus.dIn;
  assign wb_dest   = bus.instruction[DEST_LSB+ADDR_W-1:DEST_LSB];

  // r0 path has priority over the general write path, both for bypass and for commit.
  function automatic logic [DATA_W-1:0] bypass(input logic [ADDR_W-1:0] addr,
                                               input logic [DATA_W-1:0] stored);
    logic [DATA_W-1:0] val;
    val = stored;
    if (rst) begin
      val = '0;
    end else if (r0_write && (addr == '0)) begin
      val = r0_data;
    end else if (reg_write && (addr == wb_dest)) begin
      val = wb_data;
    end
    return val;
  endfunction

  always_comb begin
    bus.readDataA = bypass(bus.readAddrA, regs_q[bus.readAddrA]);
    bus.readDataB = bypass(bus.readAddrB, regs_q[bus.readAddrB]);
    bus.r0Out     = bypass('0, regs_q[0]);
  end

  assign bus.wbData      = wb_data;
  assign bus.wbDest      = wb_dest;
  assign bus.wbValid     = reg_write;
  assign bus.retireCount = retire_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q   <= '{default: '0};
      retire_q <= '0;
    end else begin
      if (reg_write) begin
        regs_q[wb_dest] <= wb_data;
      end
      if (r0_write) begin
        regs_q[0] <= r0_data;
      end
      if (reg_write || r0_write) begin
        retire_q <= retire_q + 16'd1;
      end
    end
  end

endmodule
